// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - program counter and fetch sequencer with writable jump LUT
module pc_fetch_ctrl #(
    parameter int PW = 10,
    parameter int LW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          stall,
    input  logic          halt_req,
    input  logic          branch_en,
    input  logic          cond_flag,
    input  logic [LW-1:0] lut_idx,
    input  logic          lut_we,
    input  logic [LW-1:0] lut_waddr,
    input  logic [PW-1:0] lut_wdata,
    output logic [PW-1:0] prog_ctr,
    output logic          fetch_valid,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [PW-1:0] PC_LAST = '1;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [PW-1:0] r_pc;
    logic [PW-1:0] w_pc_nxt;
    logic [PW-1:0] r_lut [2**LW];
    logic [PW-1:0] w_target;
    logic          w_taken;
    logic          w_pc_last;
    logic          w_lut_wr;

    assign w_target  = r_lut[lut_idx];
    assign w_taken   = branch_en & cond_flag;
    assign w_pc_last = (r_pc == PC_LAST);
    assign w_lut_wr  = lut_we & (r_state != S_RUN);

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        case (r_state)
            S_IDLE: begin
                w_pc_nxt = '0;
                if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                // Halt outranks stall and branch; stepping past the last address halts instead of wrapping.
                if (halt_req) begin
                    w_state_nxt = S_DONE;
                end else if (stall) begin
                    w_pc_nxt = r_pc;
                end else if (w_taken) begin
                    w_pc_nxt = w_target;
                end else if (w_pc_last) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_pc_nxt = r_pc + 1'b1;
                end
            end
            S_DONE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_pc_nxt    = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_pc_nxt    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2**LW; i++) begin
                r_lut[i] <= '0;
            end
        end else if (w_lut_wr) begin
            r_lut[lut_waddr] <= lut_wdata;
        end
    end

    assign prog_ctr    = r_pc;
    assign busy        = (r_state == S_RUN);
    assign fetch_valid = (r_state == S_RUN);
    assign done        = (r_state == S_DONE);

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - self-checking bench for pc_fetch_ctrl
module tb_pc_fetch_ctrl;

    localparam int ST_I = 0;
    localparam int ST_R = 1;
    localparam int ST_D = 2;

    typedef struct {
        logic       start;
        logic       stall;
        logic       halt;
        logic       br;
        logic       cond;
        logic [4:0] idx;
        logic       we;
        logic [4:0] waddr;
        logic [9:0] wdata;
        logic [9:0] pc;
        logic       fv;
        logic       busy;
        logic       done;
    } vec_t;

    typedef struct {
        logic [9:0] pc;
        logic       fv;
        logic       busy;
        logic       done;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, stall, halt_req, branch_en, cond_flag, lut_we;
    logic [4:0] lut_idx, lut_waddr;
    logic [9:0] lut_wdata;
    logic [9:0] prog_ctr;
    logic       fetch_valid, busy, done;
    logic [3:0] b_pc;
    logic       b_fv, b_busy, b_done;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    pc_fetch_ctrl #(.PW(10), .LW(5)) u_dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall), .halt_req(halt_req),
        .branch_en(branch_en), .cond_flag(cond_flag), .lut_idx(lut_idx), .lut_we(lut_we),
        .lut_waddr(lut_waddr), .lut_wdata(lut_wdata), .prog_ctr(prog_ctr),
        .fetch_valid(fetch_valid), .busy(busy), .done(done)
    );

    pc_fetch_ctrl #(.PW(4), .LW(5)) u_dut_small (
        .clk(clk), .reset(reset), .start(start), .stall(stall), .halt_req(halt_req),
        .branch_en(branch_en), .cond_flag(cond_flag), .lut_idx(lut_idx), .lut_we(lut_we),
        .lut_waddr(lut_waddr), .lut_wdata(lut_wdata[3:0]), .prog_ctr(b_pc),
        .fetch_valid(b_fv), .busy(b_busy), .done(b_done)
    );

    function automatic vec_t mk(input logic s, input logic st, input logic h, input logic b,
                                input logic c, input int idx, input logic we, input int wa,
                                input int wd, input int pc, input int es);
        vec_t v;
        v.start = s;  v.stall = st; v.halt = h; v.br = b; v.cond = c;
        v.idx   = 5'(idx); v.we = we; v.waddr = 5'(wa); v.wdata = 10'(wd);
        v.pc    = 10'(pc);
        v.fv    = (es == ST_R);
        v.busy  = (es == ST_R);
        v.done  = (es == ST_D);
        return v;
    endfunction

    function automatic vec_t nop(input int pc, input int es);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, pc, es);
    endfunction

    task automatic cmp(input string name, input int id, input logic [9:0] act, input logic [9:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %h expected %h", name, id, act, exp);
        end
    endtask

    task automatic check_out(input int sel, input int id);
        exp_t e;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard vec %0d: got empty queue expected an entry", id);
        end else begin
            e = sb.pop_front();
            if (sel == 0) begin
                cmp("prog_ctr", id, prog_ctr, e.pc);
                cmp("fetch_valid", id, {9'd0, fetch_valid}, {9'd0, e.fv});
                cmp("busy", id, {9'd0, busy}, {9'd0, e.busy});
                cmp("done", id, {9'd0, done}, {9'd0, e.done});
            end else begin
                cmp("b_prog_ctr", id, {6'd0, b_pc}, e.pc);
                cmp("b_fetch_valid", id, {9'd0, b_fv}, {9'd0, e.fv});
                cmp("b_busy", id, {9'd0, b_busy}, {9'd0, e.busy});
                cmp("b_done", id, {9'd0, b_done}, {9'd0, e.done});
            end
        end
    endtask

    task automatic step(input vec_t v, input int sel, input int id);
        exp_t e;
        @(negedge clk);
        start = v.start; stall = v.stall; halt_req = v.halt; branch_en = v.br;
        cond_flag = v.cond; lut_idx = v.idx; lut_we = v.we; lut_waddr = v.waddr;
        lut_wdata = v.wdata;
        e.pc = v.pc; e.fv = v.fv; e.busy = v.busy; e.done = v.done;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_out(sel, id);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        start = 0; stall = 0; halt_req = 0; branch_en = 0; cond_flag = 0;
        lut_we = 0; lut_idx = '0; lut_waddr = '0; lut_wdata = '0;
        #2;
        cmp("rst_pc", 0, prog_ctr, 10'd0);
        cmp("rst_fv", 0, {9'd0, fetch_valid}, 10'd0);
        cmp("rst_busy", 0, {9'd0, busy}, 10'd0);
        cmp("rst_done", 0, {9'd0, done}, 10'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // straight line, halt at 5
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 3, 'h040, 0, ST_I));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, ST_R));
        for (int k = 1; k <= 5; k++) tbl.push_back(nop(k, ST_R));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 5, ST_D));
        tbl.push_back(nop(5, ST_D));
        // taken branch at 2 to LUT[3]
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, ST_R));
        tbl.push_back(nop(1, ST_R));
        tbl.push_back(nop(2, ST_R));
        tbl.push_back(mk(0, 0, 0, 1, 1, 3, 0, 0, 0, 'h040, ST_R));
        tbl.push_back(nop('h041, ST_R));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 'h041, ST_D));
        // not-taken branch, stall, halt+stall
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, ST_R));
        tbl.push_back(nop(1, ST_R));
        tbl.push_back(nop(2, ST_R));
        tbl.push_back(mk(0, 0, 0, 1, 0, 3, 0, 0, 0, 3, ST_R));
        tbl.push_back(nop(4, ST_R));
        for (int k = 0; k < 3; k++) tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 4, ST_R));
        tbl.push_back(nop(5, ST_R));
        tbl.push_back(nop(6, ST_R));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 6, ST_D));
        // halt beats taken branch
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, ST_R));
        tbl.push_back(mk(0, 0, 1, 1, 1, 3, 0, 0, 0, 0, ST_D));
        // self-loop, start ignored in RUN, LUT write ignored in RUN
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 5, 1, 0, ST_D));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, ST_R));
        tbl.push_back(nop(1, ST_R));
        tbl.push_back(mk(0, 0, 0, 1, 1, 5, 0, 0, 0, 1, ST_R));
        tbl.push_back(mk(0, 0, 0, 1, 1, 5, 0, 0, 0, 1, ST_R));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 2, ST_R));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 'h3FF, 3, ST_R));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 0, 0, 0, 0, ST_R));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, ST_D));
        // LUT write in DONE takes effect; last address steps into implicit halt
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 'h3FF, 0, ST_D));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, ST_R));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 0, 0, 0, 'h3FF, ST_R));
        tbl.push_back(nop('h3FF, ST_D));
        tbl.push_back(nop('h3FF, ST_D));

        foreach (tbl[i]) step(tbl[i], 0, i);

        // asynchronous reset mid-RUN at pc 7
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, ST_R), 0, 100);
        for (int k = 1; k <= 7; k++) step(nop(k, ST_R), 0, 100 + k);
        #1;
        reset = 1'b0;
        #1;
        cmp("async_rst_pc", 110, prog_ctr, 10'd0);
        cmp("async_rst_busy", 110, {9'd0, busy}, 10'd0);
        cmp("async_rst_done", 110, {9'd0, done}, 10'd0);
        cmp("async_rst_fv", 110, {9'd0, fetch_valid}, 10'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 10; k++) step(nop(0, ST_I), 0, 120 + k);
        // LUT[3] was cleared by reset
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, ST_R), 0, 130);
        step(mk(0, 0, 0, 1, 1, 3, 0, 0, 0, 0, ST_R), 0, 131);
        step(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, ST_D), 0, 132);

        // PW=4 instance: end-of-memory behaviour
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        step(mk(0, 0, 0, 0, 0, 0, 1, 0, 14, 0, ST_I), 1, 200);
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, ST_R), 1, 201);
        step(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 14, ST_R), 1, 202);
        step(nop(15, ST_R), 1, 203);
        step(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 14, ST_R), 1, 204);
        step(nop(15, ST_R), 1, 205);
        step(nop(15, ST_D), 1, 206);
        step(nop(15, ST_D), 1, 207);
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, ST_R), 1, 208);
        step(nop(1, ST_R), 1, 209);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
